// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Registered branch resolver at the EX/MEM boundary. Evaluates the branch
// condition on the accept cycle, registers the outcome, compares it with the
// fetch-stage prediction, trains a 2-bit saturating branch history table (BHT)
// that fetch reads combinationally, and on a mispredict raises a redirect plus
// a FLUSH_CYCLES-long squash of younger instructions.
//
// Optional feature: define BRU_STATS_EN to add saturating 32-bit counters of
// resolved branches (JMP + conditional) and of mispredicts among them.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   br_valid/br_ready branch handshake (br_ready = !flush)
//   br_op             000 none, 001 JMP, 010 BEZ, 011 BNEZ,
//                     100 BLTZ, 101 BGEZ, 110 BGTZ, 111 BLEZ
//   br_pc, br_target  branch PC and taken target
//   br_data           condition operand (signed for ops 1xx)
//   pred_taken        direction fetch predicted for this branch
//   lookup_pc         fetch-stage BHT lookup address
//   lookup_taken      MSB of the indexed BHT counter (combinational)
//   res_valid         1-cycle pulse, one cycle after accept
//   taken, mispredict resolved direction and taken != pred_taken
//   redirect_addr     taken ? br_target : br_pc + INSTR_BYTES
//   flush             squash younger instructions
//   stat_branches, stat_mispredicts   (BRU_STATS_EN only)
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 32,
  parameter int BHT_DEPTH    = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int INSTR_BYTES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_op,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [DATA_W-1:0] br_data,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              lookup_taken,
  output logic              res_valid,
  output logic              taken,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic              flush
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t            state;
  logic [CNT_W-1:0]  flush_cnt;
  logic [1:0]        bht [BHT_DEPTH];

  logic              accept;
  logic              is_cond;
  logic              cond_taken;
  logic              resolve_misp;
  logic [ADDR_W-1:0] fall_through;
  logic [IDX_W-1:0]  upd_idx;
  logic [IDX_W-1:0]  lkp_idx;
  logic              unused_lookup_bits;

  assign br_ready     = !flush;
  assign accept       = br_valid && br_ready;
  // Ops 01x and 1xx are the conditional branches; 000 and 001 never train.
  assign is_cond      = br_op[2] | br_op[1];
  assign resolve_misp = cond_taken != pred_taken;
  // Wraps modulo 2^ADDR_W by construction of the fixed-width add.
  assign fall_through = br_pc + ADDR_W'(INSTR_BYTES);
  assign upd_idx      = br_pc[IDX_W+1:2];
  assign lkp_idx      = lookup_pc[IDX_W+1:2];

  // Reads the registered table, so a same-cycle update to this index is
  // only visible after the edge (read-before-write).
  assign lookup_taken = bht[lkp_idx][1];

  // Only the index bits of the lookup address select an entry.
  assign unused_lookup_bits = ^{lookup_pc[ADDR_W-1:IDX_W+2], lookup_pc[1:0]};

  // Condition evaluation; ops 1xx treat br_data as two's complement.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cond_taken = 1'b0;
    case (br_op)
      3'b000: cond_taken = 1'b0;
      3'b001: cond_taken = 1'b1;
      3'b010: cond_taken = (br_data == '0);
      3'b011: cond_taken = (br_data != '0);
      3'b100: cond_taken = br_data[DATA_W-1];
      3'b101: cond_taken = !br_data[DATA_W-1];
      3'b110: cond_taken = !br_data[DATA_W-1] && (br_data != '0);
      3'b111: cond_taken = br_data[DATA_W-1] || (br_data == '0);
    endcase
  end

  // Registered resolution result. res_valid pulses; the rest hold until
  // the next accept.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      res_valid     <= 1'b0;
      taken         <= 1'b0;
      mispredict    <= 1'b0;
      redirect_addr <= '0;
    end else begin
      res_valid <= accept;
      if (accept) begin
        taken         <= cond_taken;
        mispredict    <= resolve_misp;
        redirect_addr <= cond_taken ? br_target : fall_through;
      end
    end
  end

  // Branch history table: 2-bit saturating counters, trained only by
  // accepted conditional ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the table is reset explicitly because fetch consumes it immediately; it stays a flop array, not a RAM.
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (accept && is_cond) begin
      if (cond_taken) begin
        if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
      end else begin
        if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'd1;
      end
    end
  end

  // Flush FSM. Entered on the same edge that registers mispredict, so flush
  // rises together with the visible mispredict and lasts FLUSH_CYCLES.
  // Inputs are blocked while in FLUSH, so no accept can happen there.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      flush_cnt <= '0;
      flush     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && resolve_misp) begin
            state     <= FLUSH;
            flush_cnt <= CNT_W'(FLUSH_CYCLES);
            flush     <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt == CNT_W'(1)) begin
            state     <= IDLE;
            flush_cnt <= '0;
            flush     <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          flush_cnt <= '0;
          flush     <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRU_STATS_EN
  // Saturating statistics; op 000 is not a branch and is never counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (accept && (br_op != 3'b000)) begin
      if (stat_branches != 32'hFFFF_FFFF) stat_branches <= stat_branches + 32'd1;
      if (resolve_misp && (stat_mispredicts != 32'hFFFF_FFFF))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed bench for branch_resolve_unit with default parameters. Stimulus
// pushes the hand-computed result of every branch it expects to be accepted
// into a scoreboard queue; a monitor pops and compares on every res_valid.
// Flush timing, handshake and BHT lookups are checked inline.
// BHT index = pc[5:2]: 0x40, 0x80 -> 0; 0x44 -> 1; 0x10C -> 3; 0x3C/0xFFFFFFFC -> 15.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BEZ  = 3'b010;
  localparam logic [2:0] OP_BNEZ = 3'b011;
  localparam logic [2:0] OP_BLTZ = 3'b100;
  localparam logic [2:0] OP_BGEZ = 3'b101;
  localparam logic [2:0] OP_BGTZ = 3'b110;
  localparam logic [2:0] OP_BLEZ = 3'b111;

  localparam logic [63:0] NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic              taken;
    logic              misp;
    logic [ADDR_W-1:0] redir;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              br_valid = 1'b0;
  logic              br_ready;
  logic [2:0]        br_op = '0;
  logic [ADDR_W-1:0] br_pc = '0;
  logic [ADDR_W-1:0] br_target = '0;
  logic [DATA_W-1:0] br_data = '0;
  logic              pred_taken = 1'b0;
  logic [ADDR_W-1:0] lookup_pc = '0;
  logic              lookup_taken;
  logic              res_valid;
  logic              taken;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_addr;
  logic              flush;
`ifdef BRU_STATS_EN
  logic [31:0]       stat_branches;
  logic [31:0]       stat_mispredicts;
`endif

  int   checks = 0;
  int   failures = 0;
  int   exp_branches = 0;
  int   exp_misp = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk           (clk),
    .reset         (reset),
    .br_valid      (br_valid),
    .br_ready      (br_ready),
    .br_op         (br_op),
    .br_pc         (br_pc),
    .br_target     (br_target),
    .br_data       (br_data),
    .pred_taken    (pred_taken),
    .lookup_pc     (lookup_pc),
    .lookup_taken  (lookup_taken),
    .res_valid     (res_valid),
    .taken         (taken),
    .mispredict    (mispredict),
    .redirect_addr (redirect_addr),
    .flush         (flush)
`ifdef BRU_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one branch (caller owns timing) and records its expected result.
  task automatic drive(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic [63:0] data, input logic pred,
                       input logic e_taken, input logic e_misp, input logic [31:0] e_redir);
    exp_t e;
    br_valid   = 1'b1;
    br_op      = op;
    br_pc      = pc;
    br_target  = tgt;
    br_data    = data;
    pred_taken = pred;
    e.taken = e_taken;
    e.misp  = e_misp;
    e.redir = e_redir;
    sb.push_back(e);
    if (op != OP_NONE) begin
      exp_branches++;
      if (e_misp) exp_misp++;
    end
  endtask

  // Presents a branch from a falling edge and returns right after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic [63:0] data, input logic pred,
                       input logic e_taken, input logic e_misp, input logic [31:0] e_redir);
    @(negedge clk);
    drive(op, pc, tgt, data, pred, e_taken, e_misp, e_redir);
    @(posedge clk);
  endtask

  task automatic check_lookup(input logic [31:0] pc, input logic exp, input string name);
    @(negedge clk);
    br_valid  = 1'b0;
    lookup_pc = pc;
    #1 check(name, lookup_taken, exp);
  endtask

  // Called right after a mispredicting accept: flush and !br_ready for 2 cycles.
  // With hold=1 a wrong-path branch (not-taken BEZ at 0x44) is held valid throughout.
  task automatic expect_flush(input bit hold);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (hold) begin
        br_valid   = 1'b1;
        br_op      = OP_BEZ;
        br_pc      = 32'h44;
        br_target  = 32'h600;
        br_data    = 64'd5;
        pred_taken = 1'b0;
      end else begin
        br_valid = 1'b0;
      end
      check("flush_high", flush, 1'b1);
      check("ready_low", br_ready, 1'b0);
    end
    @(negedge clk);
    br_valid = 1'b0;
    check("flush_released", flush, 1'b0);
    check("ready_released", br_ready, 1'b1);
  endtask

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_res_valid", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_taken", taken, e.taken);
          check("res_mispredict", mispredict, e.misp);
          check("res_redirect", redirect_addr, e.redir);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_taken", taken, 1'b0);
    check("rst_mispredict", mispredict, 1'b0);
    check("rst_redirect", redirect_addr, 32'h0);
    check("rst_flush", flush, 1'b0);
    check("rst_ready", br_ready, 1'b1);
    check_lookup(32'h40, 1'b0, "lookup_reset_weak_nt");

    // Taken BEZ predicted not-taken: redirect to target, 2-cycle flush. idx0 01->10.
    issue(OP_BEZ, 32'h40, 32'h100, 64'h0, 1'b0, 1'b1, 1'b1, 32'h100);
    expect_flush(1'b0);
    check_lookup(32'h40, 1'b1, "lookup_after_first_taken");

    // Three back-to-back correctly predicted BNEZ: res_valid every cycle. idx1 -> 11.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) check("b2b_res_valid", res_valid, 1'b1);
      drive(OP_BNEZ, 32'h44, 32'h200, 64'd5, 1'b1, 1'b1, 1'b0, 32'h200);
      @(posedge clk);
    end
    @(negedge clk);
    br_valid = 1'b0;
    check("b2b_res_valid", res_valid, 1'b1);
    check("b2b_no_flush", flush, 1'b0);
    @(negedge clk);
    check("res_valid_pulse", res_valid, 1'b0);
    check("outputs_hold_taken", taken, 1'b1);

    // Signed conditions at 0x10C (idx3), all predicted correctly.
    issue(OP_BLTZ, 32'h10C, 32'h300, NEG1, 1'b1, 1'b1, 1'b0, 32'h300);
    issue(OP_BGEZ, 32'h10C, 32'h300, NEG1, 1'b0, 1'b0, 1'b0, 32'h110);
    issue(OP_BLEZ, 32'h10C, 32'h300, NEG1, 1'b1, 1'b1, 1'b0, 32'h300);
    issue(OP_BGTZ, 32'h10C, 32'h300, NEG1, 1'b0, 1'b0, 1'b0, 32'h110);
    issue(OP_BGTZ, 32'h10C, 32'h300, 64'h0, 1'b0, 1'b0, 1'b0, 32'h110);
    issue(OP_BLEZ, 32'h10C, 32'h300, 64'h0, 1'b1, 1'b1, 1'b0, 32'h300);
    check_lookup(32'h10C, 1'b0, "lookup_signed_mix");
    issue(OP_BGTZ, 32'h10C, 32'h300, 64'h1, 1'b1, 1'b1, 1'b0, 32'h300);
    issue(OP_BGEZ, 32'h10C, 32'h300, 64'h0, 1'b1, 1'b1, 1'b0, 32'h300);
    check_lookup(32'h10C, 1'b1, "lookup_signed_trained");

    // Op 000 must not train idx0 (10 -> 01 would flip the MSB); JMP always taken.
    issue(OP_NONE, 32'h40, 32'h900, 64'h0, 1'b0, 1'b0, 1'b0, 32'h44);
    issue(OP_JMP, 32'h40, 32'h400, 64'h1, 1'b1, 1'b1, 1'b0, 32'h400);
    check_lookup(32'h40, 1'b1, "lookup_none_jmp_no_update");

    // Saturation at 0x80 (idx0, starts at 10).
    repeat (4) issue(OP_BEZ, 32'h80, 32'h180, 64'h0, 1'b1, 1'b1, 1'b0, 32'h180);
    check_lookup(32'h80, 1'b1, "sat_taken_11");
    issue(OP_BEZ, 32'h80, 32'h180, 64'h1, 1'b0, 1'b0, 1'b0, 32'h84);
    check_lookup(32'h80, 1'b1, "sat_down_10");
    repeat (2) issue(OP_BEZ, 32'h80, 32'h180, 64'h1, 1'b0, 1'b0, 1'b0, 32'h84);
    check_lookup(32'h80, 1'b0, "sat_down_00");
    issue(OP_BEZ, 32'h80, 32'h180, 64'h1, 1'b0, 1'b0, 1'b0, 32'h84);
    issue(OP_BEZ, 32'h80, 32'h180, 64'h0, 1'b1, 1'b1, 1'b0, 32'h180);
    check_lookup(32'h80, 1'b0, "sat_floor_then_01");
    issue(OP_BEZ, 32'h80, 32'h180, 64'h0, 1'b1, 1'b1, 1'b0, 32'h180);
    check_lookup(32'h80, 1'b1, "sat_floor_then_10");

    // Not-taken mispredict at the top of the address space: fall-through wraps.
    // Wrong-path inputs held during flush must neither resolve nor train idx1 (11).
    issue(OP_BNEZ, 32'hFFFF_FFFC, 32'h500, 64'h0, 1'b1, 1'b0, 1'b1, 32'h0);
    expect_flush(1'b1);
    check_lookup(32'h44, 1'b1, "wrong_path_no_bht_update");
    check_lookup(32'h3C, 1'b0, "wrap_branch_trained_down");

    // Reset in the 2nd flush cycle.
    issue(OP_BEZ, 32'h40, 32'h100, 64'h0, 1'b0, 1'b1, 1'b1, 32'h100);
    @(negedge clk);
    br_valid = 1'b0;
    check("flush_c1", flush, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    exp_branches = 0;
    exp_misp = 0;
    check("flush_c2", flush, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    check("flush_after_reset", flush, 1'b0);
    check("reset_mid_taken", taken, 1'b0);
    check("reset_mid_mispredict", mispredict, 1'b0);
    check("reset_mid_redirect", redirect_addr, 32'h0);
    check_lookup(32'h44, 1'b0, "bht_reinit_idx1");
    check_lookup(32'h10C, 1'b0, "bht_reinit_idx3");

    // Reset in the 1st flush cycle: flush must drop one cycle early.
    issue(OP_BEZ, 32'h40, 32'h100, 64'h0, 1'b0, 1'b1, 1'b1, 32'h100);
    @(negedge clk);
    br_valid = 1'b0;
    check("flush_c1_early", flush, 1'b1);
    reset = 1'b1;
    exp_branches = 0;
    exp_misp = 0;
    @(negedge clk);
    reset = 1'b0;
    check("flush_early_reset", flush, 1'b0);
    check("ready_early_reset", br_ready, 1'b1);

    // Mixed traffic for the statistics: 3 branches, 2 mispredicts, one op 000.
    issue(OP_BEZ, 32'h40, 32'h100, 64'h0, 1'b1, 1'b1, 1'b0, 32'h100);
    issue(OP_BNEZ, 32'h48, 32'h700, 64'h0, 1'b1, 1'b0, 1'b1, 32'h4C);
    expect_flush(1'b0);
    issue(OP_NONE, 32'h50, 32'h900, 64'h0, 1'b0, 1'b0, 1'b0, 32'h54);
    issue(OP_JMP, 32'h54, 32'h800, 64'h0, 1'b0, 1'b1, 1'b1, 32'h800);
    expect_flush(1'b0);
    repeat (2) @(negedge clk);
`ifdef BRU_STATS_EN
    check("stat_branches", stat_branches, 32'(exp_branches));
    check("stat_mispredicts", stat_mispredicts, 32'(exp_misp));
`endif
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
